// File: rtl/aes_key_expand_iter.sv
// Iterative AES key-schedule engine for AES-128/192/256.
// Loads a cipher key, then produces one 32-bit schedule word per clock into an
// internal round-key store. Whole 128-bit round keys are read back by index
// through a registered read port.
`timescale 1ns/1ps
module aes_key_expand_iter #(
  parameter int unsigned MAX_NK   = 8,
  parameter int unsigned RK_IDX_W = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [1:0]            KEY_LEN,
  input  logic [0:32*MAX_NK-1]  CIPHER_KEY,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  KEY_READY,
  output logic                  ERR,
  input  logic [RK_IDX_W-1:0]   RK_RD_IDX,
  output logic [0:127]          RK_RD_DATA
);

  localparam int unsigned Depth = 4 * (MAX_NK + 7);
  localparam int unsigned AW    = $clog2(Depth);

  // AES S-box, entry x lives at bits [8*x +: 8].
  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {StIdle, StExpand, StFinish} state_e;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{x, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  state_e          state_q, state_d;
  logic [AW-1:0]   nk_q;
  logic [AW-1:0]   last_q;
  logic [AW-1:0]   i_q;
  logic [AW-1:0]   j_q;
  logic [7:0]      rcon_q;
  logic            key_ready_q;
  logic            err_q;
  logic [0:127]    rd_data_q;
  logic [31:0]     w_q [Depth];

  logic            len_ok;
  logic [AW-1:0]   len_nk;
  logic [AW-1:0]   len_last;
  logic            start_ok;
  logic            start_bad;
  logic [AW-1:0]   prev_idx;
  logic [AW-1:0]   old_idx;
  logic [31:0]     temp;
  logic [31:0]     new_word;
  logic            last_word;
  logic            rd_ok;
  logic [AW-1:0]   rd_base;
  logic [0:127]    rd_data_d;

  // Decode the requested key length; lengths beyond MAX_NK are rejected like 11.
  always_comb begin
    len_ok = 1'b1;
    len_nk = AW'(4);
    case (KEY_LEN)
      2'b00:   len_nk = AW'(4);
      2'b01:   len_nk = AW'(6);
      2'b10:   len_nk = AW'(8);
      default: len_ok = 1'b0;
    endcase
    if (32'(len_nk) > MAX_NK) len_ok = 1'b0;
    // Index of the final schedule word: 4*(Nk+7)-1.
    len_last  = AW'(((32'(len_nk) + 32'd7) << 2) - 32'd1);
    start_ok  = (state_q == StIdle) && START && len_ok;
    start_bad = (state_q == StIdle) && START && !len_ok;
  end

  // One schedule word per cycle: w[i] = w[i-Nk] ^ f(w[i-1]).
  always_comb begin
    // Guarded indices keep idle-time evaluation inside the store.
    prev_idx = (i_q != '0) ? i_q - AW'(1) : '0;
    old_idx  = (i_q >= nk_q) ? i_q - nk_q : '0;
    temp     = w_q[prev_idx];
    if (j_q == '0) begin
      temp = sub_word({temp[23:0], temp[31:24]}) ^ {rcon_q, 24'h000000};
    end else if (nk_q == AW'(8) && j_q == AW'(4)) begin
      temp = sub_word(temp);
    end
    new_word  = w_q[old_idx] ^ temp;
    last_word = (i_q == last_q);
  end

  // Next-state logic for the IDLE -> EXPAND -> FINISH sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (start_ok) state_d = StExpand;
      StExpand: if (last_word) state_d = StFinish;
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // State register and expansion counters.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= StIdle;
      nk_q        <= '0;
      last_q      <= '0;
      i_q         <= '0;
      j_q         <= '0;
      rcon_q      <= 8'h01;
      key_ready_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= start_bad;
      if (start_ok) begin
        nk_q        <= len_nk;
        last_q      <= len_last;
        i_q         <= len_nk;
        j_q         <= '0;
        rcon_q      <= 8'h01;
        key_ready_q <= 1'b0;
      end else if (state_q == StExpand) begin
        i_q <= i_q + AW'(1);
        if (j_q == nk_q - AW'(1)) begin
          j_q    <= '0;
          rcon_q <= xtime(rcon_q);
        end else begin
          j_q <= j_q + AW'(1);
        end
        // Becomes visible in the FINISH cycle together with DONE.
        if (last_word) key_ready_q <= 1'b1;
      end
    end
  end

  // Round-key store: key words on start, one expanded word per EXPAND cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < Depth; k++) w_q[k] <= '0;
    end else if (start_ok) begin
      for (int k = 0; k < MAX_NK; k++) begin
        if (k < int'(len_nk)) w_q[k] <= CIPHER_KEY[32*k +: 32];
      end
    end else if (state_q == StExpand) begin
      w_q[i_q] <= new_word;
    end
  end

  // Read mux: zero unless a valid schedule exists and r <= Nr.
  always_comb begin
    // An accepted start invalidates the schedule at this same edge.
    rd_ok     = key_ready_q && !start_ok && (32'(RK_RD_IDX) <= 32'(nk_q) + 32'd6);
    rd_base   = rd_ok ? AW'({RK_RD_IDX, 2'b00}) : '0;
    rd_data_d = '0;
    if (rd_ok) begin
      rd_data_d = {w_q[rd_base], w_q[rd_base + AW'(1)],
                   w_q[rd_base + AW'(2)], w_q[rd_base + AW'(3)]};
    end
  end

  // Registered read port, refreshed every cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) rd_data_q <= '0;
    else     rd_data_q <= rd_data_d;
  end

  assign BUSY       = (state_q == StExpand);
  assign DONE       = (state_q == StFinish);
  assign KEY_READY  = key_ready_q;
  assign ERR        = err_q;
  assign RK_RD_DATA = rd_data_q;

endmodule

// File: tb/tb_aes_key_expand_iter.sv
// Directed bench for aes_key_expand_iter using FIPS-197 key-expansion vectors.
`timescale 1ns/1ps
module tb_aes_key_expand_iter;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         START = 1'b0;
  logic [1:0]   KEY_LEN = 2'b00;
  logic [0:255] CIPHER_KEY = '0;
  logic         BUSY, DONE, KEY_READY, ERR;
  logic [3:0]   RK_RD_IDX = 4'd0;
  logic [0:127] RK_RD_DATA;

  int total = 0;
  int bad   = 0;

  localparam logic [255:0] Key128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] Key192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b,
                                     64'h0};
  localparam logic [255:0] Key256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] Rk128k0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] Rk128k10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] Rk192k12 = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [127:0] Rk256k14 = 128'hfe4890d1e6188d0b046df344706c631e;

  aes_key_expand_iter #(.MAX_NK(8), .RK_IDX_W(4)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .START      (START),
    .KEY_LEN    (KEY_LEN),
    .CIPHER_KEY (CIPHER_KEY),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .KEY_READY  (KEY_READY),
    .ERR        (ERR),
    .RK_RD_IDX  (RK_RD_IDX),
    .RK_RD_DATA (RK_RD_DATA)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Start an operation; returns with time in cycle T+1, #1 after its edge.
  task automatic do_start(input logic [1:0] len, input logic [255:0] key);
    @(negedge CLK);
    KEY_LEN    = len;
    CIPHER_KEY = key;
    START      = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
  endtask

  // Wait for DONE from cycle T+1; optionally pulse START (KEY_LEN=00) in cycle T+pulse_at.
  task automatic wait_done(input int pulse_at, output int lat, output int busy_n,
                           output int err_n, output int kr_n);
    lat = 1; busy_n = 0; err_n = 0; kr_n = 0;
    while (DONE !== 1'b1 && lat < 200) begin
      if (BUSY === 1'b1) busy_n++;
      if (ERR !== 1'b0) err_n++;
      if (KEY_READY !== 1'b0) kr_n++;
      if (lat == pulse_at) begin
        KEY_LEN = 2'b00;
        START   = 1'b1;
      end else begin
        START = 1'b0;
      end
      @(posedge CLK);
      #1;
      lat++;
    end
    START = 1'b0;
  endtask

  task automatic read_rk(input logic [3:0] idx, output logic [127:0] data);
    @(negedge CLK);
    RK_RD_IDX = idx;
    @(posedge CLK);
    #1;
    data = RK_RD_DATA;
  endtask

  initial begin
    int lat, busy_n, err_n, kr_n;
    logic [127:0] rd;

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    check("rst_busy", 128'(BUSY), 128'd0);
    check("rst_done", 128'(DONE), 128'd0);
    check("rst_ready", 128'(KEY_READY), 128'd0);
    check("rst_err", 128'(ERR), 128'd0);
    check("rst_rd", RK_RD_DATA, 128'd0);
    @(negedge CLK);
    RST = 1'b0;

    // AES-128
    do_start(2'b00, Key128);
    check("a128_busy_t1", 128'(BUSY), 128'd1);
    wait_done(0, lat, busy_n, err_n, kr_n);
    check("a128_latency", 128'(lat), 128'd41);
    check("a128_busy_cycles", 128'(busy_n), 128'd40);
    check("a128_ready_low_during", 128'(kr_n), 128'd0);
    check("a128_ready_at_done", 128'(KEY_READY), 128'd1);
    @(posedge CLK);
    #1;
    check("a128_done_pulse", 128'(DONE), 128'd0);
    read_rk(4'd0, rd);
    check("a128_idx0", rd, Rk128k0);
    read_rk(4'd10, rd);
    check("a128_idx10", rd, Rk128k10);
    read_rk(4'd11, rd);
    check("a128_idx11", rd, 128'd0);

    // AES-192
    do_start(2'b01, Key192);
    wait_done(0, lat, busy_n, err_n, kr_n);
    check("a192_latency", 128'(lat), 128'd47);
    check("a192_busy_cycles", 128'(busy_n), 128'd46);
    read_rk(4'd12, rd);
    check("a192_idx12", rd, Rk192k12);
    read_rk(4'd13, rd);
    check("a192_idx13", rd, 128'd0);

    // AES-256 with a stray START at T+10
    do_start(2'b10, Key256);
    wait_done(10, lat, busy_n, err_n, kr_n);
    check("a256_latency", 128'(lat), 128'd53);
    check("a256_busy_cycles", 128'(busy_n), 128'd52);
    check("a256_no_err", 128'(err_n), 128'd0);
    read_rk(4'd14, rd);
    check("a256_idx14", rd, Rk256k14);

    // Illegal key length after completion
    do_start(2'b11, Key128);
    check("illegal_err_pulse", 128'(ERR), 128'd1);
    check("illegal_not_busy", 128'(BUSY), 128'd0);
    @(posedge CLK);
    #1;
    check("illegal_err_once", 128'(ERR), 128'd0);
    check("illegal_ready_kept", 128'(KEY_READY), 128'd1);
    read_rk(4'd14, rd);
    check("illegal_idx14_kept", rd, Rk256k14);

    // Reset in the middle of a 128 run
    do_start(2'b00, Key128);
    repeat (19) @(posedge CLK);
    #1;
    check("mid_busy_before_rst", 128'(BUSY), 128'd1);
    RST = 1'b1;
    #1;
    check("mid_rst_busy", 128'(BUSY), 128'd0);
    check("mid_rst_ready", 128'(KEY_READY), 128'd0);
    check("mid_rst_rd", RK_RD_DATA, 128'd0);
    err_n = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge CLK);
      #1;
      if (c == 2) RST = 1'b0;
      if (DONE !== 1'b0) err_n++;
    end
    check("mid_rst_no_done", 128'(err_n), 128'd0);
    do_start(2'b00, Key128);
    wait_done(0, lat, busy_n, err_n, kr_n);
    check("rerun_latency", 128'(lat), 128'd41);
    read_rk(4'd10, rd);
    check("rerun_idx10", rd, Rk128k10);

    // Back-to-back: 256 then 128
    do_start(2'b10, Key256);
    wait_done(0, lat, busy_n, err_n, kr_n);
    read_rk(4'd14, rd);
    check("b2b_256_idx14", rd, Rk256k14);
    do_start(2'b00, Key128);
    check("b2b_ready_dropped", 128'(KEY_READY), 128'd0);
    check("b2b_rd_zero_busy", RK_RD_DATA, 128'd0);
    wait_done(0, lat, busy_n, err_n, kr_n);
    check("b2b_ready_low_during", 128'(kr_n), 128'd0);
    check("b2b_latency", 128'(lat), 128'd41);
    read_rk(4'd14, rd);
    check("b2b_idx14_zero", rd, 128'd0);
    read_rk(4'd10, rd);
    check("b2b_idx10", rd, Rk128k10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
